// File: rtl/parity_step_counter_pkg.sv
// rtl/parity_step_counter_pkg.sv - shared types, mode constants and limit helper for the parity step counter
package parity_step_pkg;

  // Action taken on an enabled edge: step by +/-STEP, or a one-off +1 parity fix
  typedef enum logic {
    S_STEP  = 1'b0,
    S_ALIGN = 1'b1
  } state_e;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Parity-correct range limit: dir=1 gives MAXP, dir=0 gives MINP
  function automatic logic [31:0] limit_val(input int unsigned width, input logic parity,
                                            input logic dir);
    logic [31:0] top;
    top = (32'd1 << width) - 32'd1;
    if (dir) return parity ? top : top - 32'd1;
    else     return parity ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/parity_step_counter_if.sv
// rtl/parity_step_counter_if.sv - control and status bundle of the parity step counter
interface parity_step_counter_if
  import parity_step_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             P;
  logic             F;
  logic [WIDTH-1:0] out_count;
  logic             aligned;
  logic             wrap_o;
  logic             sat_o;
  state_e           fsm_state;

  modport master (
    output en, load, load_val, P, F,
    input  out_count, aligned, wrap_o, sat_o, fsm_state
  );

  modport slave (
    input  en, load, load_val, P, F,
    output out_count, aligned, wrap_o, sat_o, fsm_state
  );
endinterface

// File: rtl/parity_step_counter_alu.sv
// rtl/parity_step_counter_alu.sv - combinational next-value logic with wrap/saturate detection
module parity_step_alu
  import parity_step_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP     = 2,
  parameter int SAT_MODE = 0
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic             i_p,
  input  logic             i_f,
  input  state_e           i_state,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_sat
);

  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_EVEN = ALL_ONES - 1'b1;

  logic [WIDTH:0] w_ext;
  logic [WIDTH:0] w_sum;

  // One extra bit of headroom: bit WIDTH flags overflow (up) or borrow (down)
  always_comb begin
    w_ext  = {1'b0, i_cur};
    w_sum  = w_ext;
    o_next = i_cur;
    o_wrap = 1'b0;
    o_sat  = 1'b0;
    if (i_state == S_ALIGN) begin
      if (SAT_MODE == SAT_CLAMP && i_cur == ALL_ONES && !i_p) begin
        // Cannot step +1 past the top when clamping, so fix parity downwards instead
        o_next = MAX_EVEN;
        o_sat  = 1'b1;
      end else begin
        w_sum  = w_ext + ONE_X;
        o_next = w_sum[WIDTH-1:0];
        o_wrap = w_sum[WIDTH];
      end
    end else begin
      w_sum = i_f ? (w_ext + STEP_X) : (w_ext - STEP_X);
      if (w_sum[WIDTH]) begin
        if (SAT_MODE == SAT_CLAMP) begin
          o_next = WIDTH'(limit_val(WIDTH, i_p, i_f));
          o_sat  = 1'b1;
        end else begin
          o_next = w_sum[WIDTH-1:0];
          o_wrap = 1'b1;
        end
      end else begin
        o_next = w_sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/parity_step_counter.sv
// rtl/parity_step_counter.sv - parity-forcing stepping counter with load, enable and limit handling
module parity_step_counter
  import parity_step_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP     = 2,
  parameter int SAT_MODE = 0
) (
  input logic                  clk,
  input logic                  rst,
  parity_step_counter_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("parity_step_counter: WIDTH must be >= 2");
  end
  if ((STEP % 2) != 0 || STEP < 2 || STEP > (1 << (WIDTH - 1))) begin : g_bad_step
    $error("parity_step_counter: STEP must be even and within 2..2^(WIDTH-1)");
  end
  if (SAT_MODE != SAT_WRAP && SAT_MODE != SAT_CLAMP) begin : g_bad_mode
    $error("parity_step_counter: SAT_MODE must be 0 or 1");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic             r_aligned;
  logic             r_wrap;
  logic             r_sat;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_sat;

  // Parity is re-checked every enabled cycle, so a P change costs exactly one align cycle
  always_comb begin
    w_state_nxt = S_STEP;
    if (r_count[0] != bus.P) w_state_nxt = S_ALIGN;
  end

  parity_step_alu #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .SAT_MODE (SAT_MODE)
  ) u_alu (
    .i_cur   (r_count),
    .i_p     (bus.P),
    .i_f     (bus.F),
    .i_state (w_state_nxt),
    .o_next  (w_next),
    .o_wrap  (w_wrap),
    .o_sat   (w_sat)
  );

  // State register records the action of the last enabled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_STEP;
    end else if (!bus.load && bus.en) begin
      r_state <= w_state_nxt;
    end
  end

  // Count and status: load beats enable; flags are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_aligned <= 1'b1;
      r_wrap    <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.load) begin
      r_count   <= bus.load_val;
      r_aligned <= (bus.load_val[0] == bus.P);
      r_wrap    <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.en) begin
      r_count   <= w_next;
      r_aligned <= 1'b1;
      r_wrap    <= w_wrap;
      r_sat     <= w_sat;
    end else begin
      r_wrap    <= 1'b0;
      r_sat     <= 1'b0;
    end
  end

  assign bus.out_count = r_count;
  assign bus.aligned   = r_aligned;
  assign bus.wrap_o    = r_wrap;
  assign bus.sat_o     = r_sat;
  assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_parity_step_counter.sv
// tb/tb_parity_step_counter.sv - scoreboard bench for wrap and saturate builds of the parity step counter
module tb_parity_step_counter;
  import parity_step_pkg::*;

  localparam int W    = 4;
  localparam int ST   = 2;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int cnt;
    bit al;
    bit wr;
    bit sa;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_step_counter_if #(.WIDTH(W)) bw ();
  parity_step_counter_if #(.WIDTH(W)) bs ();

  parity_step_counter #(.WIDTH(W), .STEP(ST), .SAT_MODE(0)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bw.slave)
  );

  parity_step_counter #(.WIDTH(W), .STEP(ST), .SAT_MODE(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs.slave)
  );

  exp_t qw[$];
  exp_t qs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state, index 0 = wrap build, 1 = saturate build
  int mc[2];
  bit ma[2];
  bit mw[2];
  bit ms[2];

  function automatic void cmp(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endfunction

  function automatic void model_update(int m, bit r, bit ld, int lv, bit e, bit p, bit f);
    int t;
    if (r) begin
      mc[m] = 0; ma[m] = 1; mw[m] = 0; ms[m] = 0;
    end else if (ld) begin
      mc[m] = lv; ma[m] = ((lv % 2) == int'(p)); mw[m] = 0; ms[m] = 0;
    end else if (e) begin
      mw[m] = 0; ms[m] = 0; ma[m] = 1;
      if ((mc[m] % 2) != int'(p)) begin
        if (m == 1 && mc[m] == MAXV && !p) begin
          mc[m] = MAXV - 1; ms[m] = 1;
        end else begin
          t = mc[m] + 1;
          if (t > MAXV) begin t = 0; mw[m] = 1; end
          mc[m] = t;
        end
      end else begin
        t = f ? mc[m] + ST : mc[m] - ST;
        if (t > MAXV || t < 0) begin
          if (m == 1) begin
            mc[m] = f ? (p ? MAXV : MAXV - 1) : (p ? 1 : 0);
            ms[m] = 1;
          end else begin
            mc[m] = (t + MAXV + 1) % (MAXV + 1);
            mw[m] = 1;
          end
        end else begin
          mc[m] = t;
        end
      end
    end else begin
      mw[m] = 0; ms[m] = 0;
    end
  endfunction

  task automatic drive(bit r, bit ld, int lv, bit e, bit p, bit f);
    exp_t x;
    @(negedge clk);
    rst = r;
    bw.load = ld; bw.load_val = W'(lv); bw.en = e; bw.P = p; bw.F = f;
    bs.load = ld; bs.load_val = W'(lv); bs.en = e; bs.P = p; bs.F = f;
    for (int m = 0; m < 2; m++) begin
      model_update(m, r, ld, lv, e, p, f);
      x.cnt = mc[m]; x.al = ma[m]; x.wr = mw[m]; x.sa = ms[m];
      if (m == 0) qw.push_back(x);
      else        qs.push_back(x);
    end
  endtask

  // Monitor: every edge the DUT presents a new result; compare it with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (qw.size() > 0) begin
        e = qw.pop_front();
        cmp("wrap.count",   int'(bw.out_count), e.cnt);
        cmp("wrap.aligned", int'(bw.aligned),   int'(e.al));
        cmp("wrap.wrap_o",  int'(bw.wrap_o),    int'(e.wr));
        cmp("wrap.sat_o",   int'(bw.sat_o),     int'(e.sa));
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        cmp("sat.count",   int'(bs.out_count), e.cnt);
        cmp("sat.aligned", int'(bs.aligned),   int'(e.al));
        cmp("sat.wrap_o",  int'(bs.wrap_o),    int'(e.wr));
        cmp("sat.sat_o",   int'(bs.sat_o),     int'(e.sa));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    bit f;
    bw.load = 0; bw.load_val = '0; bw.en = 0; bw.P = 0; bw.F = 0;
    bs.load = 0; bs.load_val = '0; bs.en = 0; bs.P = 0; bs.F = 0;

    // Reset, then odd counting up
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, 1);

    // Top-of-range wrap up, then wrap down through zero
    drive(0, 1, 14, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Saturation at the odd limit, then parity switch at the top
    drive(0, 1, 13, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);

    // Saturation at the bottom going down
    drive(0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);

    // Mid-run parity switch while counting down
    drive(0, 1, 6, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);

    // Load wins over enable even with mismatched parity; hold drops flags
    drive(0, 1, 5, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1);

    // Asynchronous reset between edges while sitting at 9
    drive(0, 1, 9, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #3;
    rst = 1;
    for (int m = 0; m < 2; m++) model_update(m, 1, 0, 0, 0, 0, 0);
    #1;
    cmp("async.wrap.count", int'(bw.out_count), 0);
    cmp("async.wrap.flags", int'({bw.aligned, bw.wrap_o, bw.sat_o}), 4);
    cmp("async.sat.count",  int'(bs.out_count), 0);
    cmp("async.sat.flags",  int'({bs.aligned, bs.wrap_o, bs.sat_o}), 4);
    drive(1, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);

    // Randomized traffic with sticky P/F and occasional load/reset
    p = 0;
    f = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) p = ~p;
      if ($urandom_range(0, 7) == 0) f = ~f;
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
            int'($urandom_range(0, MAXV)), ($urandom_range(0, 3) != 0), p, f);
    end

    drive(0, 0, 0, 0, p, f);
    repeat (3) @(posedge clk);
    #3;
    cmp("drain.wrap", qw.size(), 0);
    cmp("drain.sat",  qs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
